regfile_commit_sequencer: RTL

Sits between the ROB retire stage and the register file's single commit port. Accepts in-order retire requests from the ROB over a valid/ready handshake and buffers them in a small FIFO. Issues at most one commit per cycle to the register file. Holds a commit while decode is renaming the same destination register that cycle, and discards everything on a pipeline flush.

---
 rtl/regfile_commit_sequencer_if.sv | 39 +++
 rtl/regfile_commit_sequencer.sv | 122 ++++++++++++
 2 files changed

// File: rtl/regfile_commit_sequencer_if.sv
// Retire bus from the ROB and commit bus to the register file.
// slave = sequencer side, master = ROB/regfile side.
interface regfile_commit_sequencer_if #(
  parameter int GPR_IDX_W = 5,
  parameter int GPR_W     = 64,
  parameter int ROB_IDX_W = 4
);
  // ROB retire handshake
  logic                 in_rob_retire_valid;
  logic                 out_rob_retire_ready;
  logic [GPR_IDX_W-1:0] in_rob_reg_index;
  logic [GPR_W-1:0]     in_rob_value;
  logic [ROB_IDX_W-1:0] in_rob_rob_index;
  logic                 in_rob_set_nzcv;
  logic [3:0]           in_rob_nzcv;
  // register file commit port
  logic                 out_reg_should_commit;
  logic [GPR_IDX_W-1:0] out_reg_reg_index;
  logic [GPR_W-1:0]     out_reg_commit_value;
  logic [ROB_IDX_W-1:0] out_reg_commit_rob_index;
  logic                 out_reg_set_nzcv;
  logic [3:0]           out_reg_nzcv;

  modport slave (
    input  in_rob_retire_valid, in_rob_reg_index, in_rob_value,
           in_rob_rob_index, in_rob_set_nzcv, in_rob_nzcv,
    output out_rob_retire_ready,
    output out_reg_should_commit, out_reg_reg_index, out_reg_commit_value,
           out_reg_commit_rob_index, out_reg_set_nzcv, out_reg_nzcv
  );

  modport master (
    output in_rob_retire_valid, in_rob_reg_index, in_rob_value,
           in_rob_rob_index, in_rob_set_nzcv, in_rob_nzcv,
    input  out_rob_retire_ready,
    input  out_reg_should_commit, out_reg_reg_index, out_reg_commit_value,
           out_reg_commit_rob_index, out_reg_set_nzcv, out_reg_nzcv
  );
endinterface

// File: rtl/regfile_commit_sequencer.sv
// Buffers in-order ROB retires in a small FIFO and drives the register file's
// single commit port, one commit per cycle. The head is held while decode
// renames the same destination; a flush drops everything buffered.
module regfile_commit_sequencer #(
  parameter int DEPTH     = 4,
  parameter int GPR_IDX_W = 5,
  parameter int GPR_W     = 64,
  parameter int ROB_IDX_W = 4,
  parameter int XZR_IDX   = 31
) (
  input  logic                       in_clk,
  input  logic                       in_rst,
  regfile_commit_sequencer_if.slave  bus,
  input  logic                       in_d_done,
  input  logic [GPR_IDX_W-1:0]       in_d_dst,
  input  logic                       in_flush,
  output logic [$clog2(DEPTH):0]     out_count,
  output logic                       out_empty,
  output logic [15:0]                out_hazard_stalls
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]        FULL_C = CW'(DEPTH);
  localparam logic [GPR_IDX_W-1:0] XZR_C  = GPR_IDX_W'(XZR_IDX);

  typedef struct packed {
    logic [GPR_IDX_W-1:0] reg_index;
    logic [GPR_W-1:0]     value;
    logic [ROB_IDX_W-1:0] rob_index;
    logic                 set_nzcv;
    logic [3:0]           nzcv;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head_e, in_e;
  logic [PW-1:0]   head, tail;
  logic [CW-1:0]   count;
  logic            ready, push, pop, hazard, silent;

  // registered commit port
  logic                 c_strobe, c_set_nzcv;
  logic [GPR_IDX_W-1:0] c_reg_index;
  logic [GPR_W-1:0]     c_value;
  logic [ROB_IDX_W-1:0] c_rob_index;
  logic [3:0]           c_nzcv;

  assign in_e = '{reg_index: bus.in_rob_reg_index, value: bus.in_rob_value,
                  rob_index: bus.in_rob_rob_index, set_nzcv: bus.in_rob_set_nzcv,
                  nzcv: bus.in_rob_nzcv};
  assign head_e = mem[head];

  // Head entry is stale when empty; pop qualifies with count so that is harmless.
  assign hazard = in_d_done && (in_d_dst == head_e.reg_index) && (head_e.reg_index != XZR_C);
  // Ready looks only at current occupancy, so a full FIFO refuses even if it pops.
  assign ready  = !in_rst && (count < FULL_C);
  assign push   = bus.in_rob_retire_valid && ready && !in_flush;
  assign pop    = (count != '0) && !hazard && !in_flush;
  // Zero-register writes without flags retire with no visible effect.
  assign silent = (head_e.reg_index == XZR_C) && !head_e.set_nzcv;

  // Entry storage; no reset needed since count gates every read.
  always_ff @(posedge in_clk) begin
    if (push) mem[tail] <= in_e;
  end

  // Pointers and occupancy; reset and flush both empty the FIFO.
  always_ff @(posedge in_clk) begin
    if (in_rst || in_flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Commit port: strobes are single-cycle, data holds between commits.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      c_strobe    <= 1'b0;
      c_set_nzcv  <= 1'b0;
      c_reg_index <= '0;
      c_value     <= '0;
      c_rob_index <= '0;
      c_nzcv      <= '0;
    end else if (pop) begin
      c_strobe    <= !silent;
      c_set_nzcv  <= head_e.set_nzcv;
      c_reg_index <= head_e.reg_index;
      c_value     <= head_e.value;
      c_rob_index <= head_e.rob_index;
      c_nzcv      <= head_e.nzcv;
    end else begin
      c_strobe    <= 1'b0;
      c_set_nzcv  <= 1'b0;
    end
  end

  // Saturating count of cycles the head was held by a rename hazard.
  always_ff @(posedge in_clk) begin
    if (in_rst)
      out_hazard_stalls <= '0;
    else if ((count != '0) && hazard && !in_flush && (out_hazard_stalls != 16'hFFFF))
      out_hazard_stalls <= out_hazard_stalls + 16'd1;
  end

  assign bus.out_rob_retire_ready     = ready;
  assign bus.out_reg_should_commit    = c_strobe;
  assign bus.out_reg_set_nzcv         = c_set_nzcv;
  assign bus.out_reg_reg_index        = c_reg_index;
  assign bus.out_reg_commit_value     = c_value;
  assign bus.out_reg_commit_rob_index = c_rob_index;
  assign bus.out_reg_nzcv             = c_nzcv;
  assign out_count = count;
  assign out_empty = (count == '0);
endmodule
